// File: rtl/timer_param.sv
// timer_param: Avalon-MM interval timer with programmable period, start/stop,
// one-shot or continuous mode, a 16- or 32-bit down-counter and a snapshot
// register. Defining TIMER_PRESCALE_EN adds a 16-bit clock prescaler at
// word address 6; without it every clk is a counter tick.
module timer_param #(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999,
  parameter int RUN_AT_RESET   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  if (CNT_W != 16 && CNT_W != 32) begin : g_bad_cnt_w
    $error("timer_param: CNT_W must be 16 or 32");
  end

  localparam logic [2:0] A_STATUS   = 3'd0;
  localparam logic [2:0] A_CONTROL  = 3'd1;
  localparam logic [2:0] A_PERIOD_L = 3'd2;
  localparam logic [2:0] A_PERIOD_H = 3'd3;
  localparam logic [2:0] A_SNAP_L   = 3'd4;
  localparam logic [2:0] A_SNAP_H   = 3'd5;
  localparam logic [2:0] A_PRESCALE = 3'd6;

  localparam logic             RUN_RST = (RUN_AT_RESET != 0);
  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] cnt_q, period_q, period_d, snap_q;
  logic             to_q, run_q, ito_q, cont_q, reload_q;
  logic [15:0]      rdata_q, rdata_d;
  logic [31:0]      period_ext, snap_ext, period_w;
  logic [15:0]      presc_rd;
  logic             wr, rd, wr_status, wr_ctrl, wr_period, wr_snap;
  logic             start_w, stop_w, start_reload, tick, wrap;

  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & write_n;
  assign wr_status = wr && (address == A_STATUS);
  assign wr_ctrl   = wr && (address == A_CONTROL);
  assign wr_period = wr && (address == A_PERIOD_L || address == A_PERIOD_H);
  assign wr_snap   = wr && (address == A_SNAP_L || address == A_SNAP_H);

  // STOP beats START when both strobes arrive in one write.
  assign stop_w       = wr_ctrl & writedata[3];
  assign start_w      = wr_ctrl & writedata[2] & ~writedata[3];
  assign start_reload = start_w & ~run_q;

  // Zero-extended views make the upper halves read 0 when CNT_W is 16.
  assign period_ext = 32'(period_q);
  assign snap_ext   = 32'(snap_q);

  // Merge a half-word write into the period; the upper half falls away when CNT_W is 16.
  always_comb begin
    period_w = period_ext;
    if (wr && address == A_PERIOD_L) period_w[15:0]  = writedata;
    if (wr && address == A_PERIOD_H) period_w[31:16] = writedata;
    period_d = CNT_W'(period_w);
  end

`ifdef TIMER_PRESCALE_EN
  logic [15:0] presc_q, pcnt_q;
  logic        wr_presc;

  assign wr_presc = wr && (address == A_PRESCALE);
  assign tick     = run_q && (pcnt_q == 16'd0);
  assign presc_rd = presc_q;

  // Prescale divider: counts PRESCALE..0 while running, restarts on period/prescale writes and start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= 16'd0;
      pcnt_q  <= 16'd0;
    end else begin
      if (wr_presc) presc_q <= writedata;
      if (wr_presc)                        pcnt_q <= writedata;
      else if (wr_period || start_reload)  pcnt_q <= presc_q;
      else if (run_q)                      pcnt_q <= (pcnt_q == 16'd0) ? presc_q : pcnt_q - 16'd1;
    end
  end
`else
  assign tick     = run_q;
  assign presc_rd = 16'd0;
`endif

  assign wrap = tick && (cnt_q == '0);

  // Period register and down-counter; a pending period reload overrides counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= PER_RST;
      cnt_q    <= PER_RST;
      reload_q <= 1'b0;
    end else begin
      period_q <= period_d;
      reload_q <= wr_period;
      if (reload_q || start_reload || wrap) cnt_q <= period_q;
      else if (tick)                        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Control and status flags; a timeout set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q   <= 1'b0;
      run_q  <= RUN_RST;
      ito_q  <= 1'b0;
      cont_q <= RUN_RST;
    end else begin
      if (wr_ctrl) begin
        ito_q  <= writedata[0];
        cont_q <= writedata[1];
      end
      if (stop_w)              run_q <= 1'b0;
      else if (start_w)        run_q <= 1'b1;
      else if (wrap && !cont_q) run_q <= 1'b0;
      if (wrap)           to_q <= 1'b1;
      else if (wr_status) to_q <= 1'b0;
    end
  end

  // Register read mux; START/STOP are strobes and read as 0.
  always_comb begin
    rdata_d = 16'd0;
    case (address)
      A_STATUS:   rdata_d = {14'd0, run_q, to_q};
      A_CONTROL:  rdata_d = {14'd0, cont_q, ito_q};
      A_PERIOD_L: rdata_d = period_ext[15:0];
      A_PERIOD_H: rdata_d = period_ext[31:16];
      A_SNAP_L:   rdata_d = snap_ext[15:0];
      A_SNAP_H:   rdata_d = snap_ext[31:16];
      A_PRESCALE: rdata_d = presc_rd;
      default:    rdata_d = 16'd0;
    endcase
  end

  // Snapshot captures the pre-decrement count; readdata is registered one clk after the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q  <= '0;
      rdata_q <= 16'd0;
    end else begin
      if (wr_snap) snap_q  <= cnt_q;
      if (rd)      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = to_q & ito_q;

endmodule

// File: tb/tb_timer_param.sv
// Bench for timer_param: a 16-bit instance running from reset and a 32-bit
// instance that starts stopped. Reads push their expected value onto a
// scoreboard queue and are popped once readdata is valid.
module tb_timer_param;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address    [2];
  logic        chipselect [2];
  logic        write_n    [2];
  logic [15:0] writedata  [2];
  logic [15:0] readdata   [2];
  logic        irq        [2];

  always #5 clk = ~clk;

  timer_param #(.CNT_W(16), .DEFAULT_PERIOD(4), .RUN_AT_RESET(1)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .address(address[0]), .chipselect(chipselect[0]),
    .write_n(write_n[0]), .writedata(writedata[0]), .readdata(readdata[0]), .irq(irq[0]));

  timer_param #(.CNT_W(32), .DEFAULT_PERIOD(4), .RUN_AT_RESET(0)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .address(address[1]), .chipselect(chipselect[1]),
    .write_n(write_n[1]), .writedata(writedata[1]), .readdata(readdata[1]), .irq(irq[1]));

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

`ifdef TIMER_PRESCALE_EN
  localparam int PRE_RD = 2;
  localparam int FIRST  = 10;
  localparam int PER    = 6;
`else
  localparam int PRE_RD = 0;
  localparam int FIRST  = 6;
  localparam int PER    = 2;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input int s, input logic [2:0] a, input logic [15:0] d);
    address[s]    = a;
    writedata[s]  = d;
    write_n[s]    = 1'b0;
    chipselect[s] = 1'b1;
    @(posedge clk); #1;
    chipselect[s] = 1'b0;
    write_n[s]    = 1'b1;
  endtask

  task automatic bus_rd(input int s, input logic [2:0] a, input logic [15:0] exp, input string tag);
    rd_exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = exp;
    sb_q.push_back(e);
    address[s]    = a;
    write_n[s]    = 1'b1;
    chipselect[s] = 1'b1;
    @(posedge clk); #1;
    chipselect[s] = 1'b0;
    e = sb_q.pop_front();
    check(e.tag, 32'(readdata[e.sel]), 32'(e.exp));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Assert reset away from the edge, check outputs clear at once, release so
  // the bench resumes in cycle 0.
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check({tag, "_rst_rd16"},  32'(readdata[0]), 32'd0);
    check({tag, "_rst_irq16"}, 32'(irq[0]),      32'd0);
    check({tag, "_rst_rd32"},  32'(readdata[1]), 32'd0);
    check({tag, "_rst_irq32"}, 32'(irq[1]),      32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      address[i]    = 3'd0;
      chipselect[i] = 1'b0;
      write_n[i]    = 1'b1;
      writedata[i]  = 16'd0;
    end

    // A: run from reset, period 4 -> TO at cycle 5, then every 5 clks
    do_reset("A");
    for (int k = 0; k <= 5; k++) begin
      bus_rd(0, 3'd0, (k == 5) ? 16'h3 : 16'h2, "A_status");
      check("A_irq_off", 32'(irq[0]), 32'd0);
    end
    bus_wr(0, 3'd0, 16'h0);
    for (int k = 7; k <= 10; k++) bus_rd(0, 3'd0, (k == 10) ? 16'h3 : 16'h2, "A_status2");

    // B: PERIOD_L=9 reload, timeout 10 clks after reload, irq via ITO
    do_reset("B");
    bus_wr(0, 3'd2, 16'd9);
    for (int k = 1; k <= 12; k++) begin
      bus_rd(0, 3'd0, (k == 12) ? 16'h3 : 16'h2, "B_status");
      check("B_irq_off", 32'(irq[0]), 32'd0);
    end
    bus_wr(0, 3'd1, 16'h3);
    check("B_irq_on", 32'(irq[0]), 32'd1);
    bus_wr(0, 3'd0, 16'h0);
    check("B_irq_clr", 32'(irq[0]), 32'd0);
    bus_rd(0, 3'd0, 16'h2, "B_status_clr");
    bus_rd(0, 3'd1, 16'h3, "B_control");

    // C: one-shot with period 3, counter holds 3 afterwards; 16-bit upper halves read 0
    do_reset("C");
    bus_wr(0, 3'd1, 16'h8);
    bus_wr(0, 3'd2, 16'd3);
    bus_wr(0, 3'd1, 16'h4);
    for (int k = 3; k <= 12; k++) bus_rd(0, 3'd0, (k < 7) ? 16'h2 : 16'h1, "C_status");
    bus_wr(0, 3'd4, 16'h0);
    bus_rd(0, 3'd4, 16'd3, "C_snap_l");
    bus_rd(0, 3'd5, 16'd0, "C_snap_h16");
    bus_wr(0, 3'd3, 16'h1234);
    bus_rd(0, 3'd3, 16'd0, "C_period_h16");
    bus_rd(0, 3'd2, 16'd3, "C_period_l");
    bus_rd(0, 3'd1, 16'h0, "C_control");

    // D: 32-bit period 0x10000, snapshot after 5 clks
    do_reset("D");
    bus_rd(1, 3'd0, 16'h0, "D_status_reset");
    bus_wr(1, 3'd2, 16'h0);
    bus_wr(1, 3'd3, 16'h1);
    bus_wr(1, 3'd1, 16'h6);
    idle(5);
    bus_wr(1, 3'd4, 16'h0);
    bus_rd(1, 3'd4, 16'hFFFB, "D_snap_l");
    bus_rd(1, 3'd5, 16'h0000, "D_snap_h");
    bus_rd(1, 3'd3, 16'h0001, "D_period_h");
    bus_rd(1, 3'd2, 16'h0000, "D_period_l");
    bus_wr(1, 3'd5, 16'h0);
    bus_rd(1, 3'd4, 16'hFFF6, "D_snap_l2");

    // E: START+STOP together, status write during wrap, period write during wrap
    do_reset("E");
    bus_wr(1, 3'd2, 16'd2);
    bus_wr(1, 3'd1, 16'hC);
    bus_rd(1, 3'd0, 16'h0, "E_start_stop");
    bus_wr(1, 3'd1, 16'h6);
    idle(2);
    bus_wr(1, 3'd0, 16'h0);
    bus_rd(1, 3'd0, 16'h3, "E_to_wins");
    bus_wr(1, 3'd0, 16'h0);
    bus_wr(1, 3'd2, 16'd5);
    bus_rd(1, 3'd0, 16'h3, "E_period_wrap_to");
    bus_wr(1, 3'd0, 16'h0);
    for (int k = 12; k <= 17; k++) bus_rd(1, 3'd0, (k == 17) ? 16'h3 : 16'h2, "E_new_period");

    // F: prescaler register and timeout spacing with PERIOD=1
    do_reset("F");
    bus_wr(1, 3'd6, 16'd2);
    bus_rd(1, 3'd6, 16'(PRE_RD), "F_prescale_rd");
    bus_wr(1, 3'd2, 16'd1);
    bus_wr(1, 3'd1, 16'h6);
    for (int k = 4; k <= FIRST; k++) bus_rd(1, 3'd0, (k == FIRST) ? 16'h3 : 16'h2, "F_first_to");
    bus_wr(1, 3'd0, 16'h0);
    for (int k = FIRST + 2; k <= FIRST + 2 * PER; k++)
      bus_rd(1, 3'd0, (k >= FIRST + PER) ? 16'h3 : 16'h2, "F_next_to");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
